// File: rtl/dtc_pkg.sv
// Shared definitions for the DTC prescan block: parameter defaults, FSM state
// type, class label type and output FIFO geometry.
package dtc_pkg;

    localparam int unsigned FEAT_W_DEF = 8;
    localparam int unsigned CLS_W_DEF  = 2;

    // Output FIFO geometry
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [CLS_W_DEF-1:0] cls_t;

endpackage

// File: rtl/dtc_prescan_if.sv
// Output stream of matching feature vectors.
//   m_valid_o : data available (master -> slave)
//   m_ready_i : sink accepts   (slave -> master)
//   m_data_o  : feature vector (master -> slave)
interface dtc_prescan_if #(
    parameter int unsigned FEAT_W = 8
) ();
    logic              m_valid_o;
    logic              m_ready_i;
    logic [FEAT_W-1:0] m_data_o;

    modport master (output m_valid_o, output m_data_o, input m_ready_i);
    modport slave  (input m_valid_o, input m_data_o, output m_ready_i);
endinterface

// File: rtl/dtc_sfifo.sv
// Four-entry synchronous FIFO holding matched candidates.
//   clk, rst_n : clock, synchronous active-low reset (discards contents)
//   push/wdata : write side; push is ignored while full
//   pop/rdata  : read side; rdata is the head entry, pop ignored while empty
//   full, empty, count : occupancy status
module dtc_sfifo
    import dtc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array needs no reset; occupancy tracking decides validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + FIFO_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - FIFO_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/dtc_prescan.sv
// Exhaustive prescan: walks every FEAT_W-bit candidate through an external
// classifier and streams out, in ascending order, those whose label equals
// the requested target class.
//   clk, rst_n   : clock, synchronous active-low reset
//   start_i      : one-cycle scan request (honoured in IDLE only)
//   target_i     : class to search for, captured on accepted start
//   feat_o       : candidate presented to the classifier
//   cls_i        : classifier label for feat_o of LAT cycles earlier
//   m_if         : matched-vector output stream (master side)
//   match_cnt_o  : beats accepted downstream in the current/last scan
//   busy_o       : scan in progress
//   done_o       : one-cycle end-of-scan pulse
//   hist_o       : per-class label counts, only with DTC_PRESCAN_HIST_EN
module dtc_prescan
    import dtc_pkg::*;
#(
    parameter int unsigned FEAT_W = FEAT_W_DEF,
    parameter int unsigned CLS_W  = CLS_W_DEF,
    parameter int unsigned LAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CLS_W-1:0]  target_i,
    output logic [FEAT_W-1:0] feat_o,
    input  logic [CLS_W-1:0]  cls_i,
    dtc_prescan_if.master     m_if,
    output logic [FEAT_W:0]   match_cnt_o,
    output logic              busy_o,
    output logic              done_o
`ifdef DTC_PRESCAN_HIST_EN
    ,
    output logic [3:0][FEAT_W:0] hist_o
`endif
);

    localparam int unsigned CNT_W = FEAT_W + 1;

    state_t                state_q;
    state_t                state_d;
    logic [FEAT_W-1:0]     cand_q;
    logic [FEAT_W-1:0]     pipe_cand_q;
    logic                  pipe_v_q;
    logic [CLS_W-1:0]      target_q;
    logic [CNT_W-1:0]      match_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  busy_d;
    logic                  done_d;
    logic                  inflight;
    logic                  issue;
    logic                  ret_v;
    logic [FEAT_W-1:0]     ret_cand;
    logic                  push;
    logic                  pop;
    logic                  cand_last;
    logic                  drain_empty;
    logic                  start_acc;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [FIFO_CNT_W-1:0] fifo_free;

    // Only issue when every in-flight label is guaranteed a FIFO slot
    assign inflight    = (LAT == 0) ? 1'b0 : pipe_v_q;
    assign fifo_free   = FIFO_CNT_W'(FIFO_DEPTH) - fifo_cnt;
    assign issue       = (state_q == ST_SCAN) && !fifo_full
                         && (fifo_free > FIFO_CNT_W'(inflight));
    assign ret_v       = (LAT == 0) ? issue : pipe_v_q;
    assign ret_cand    = (LAT == 0) ? cand_q : pipe_cand_q;
    assign push        = ret_v && (cls_i == target_q);
    assign pop         = m_if.m_valid_o && m_if.m_ready_i;
    assign cand_last   = &cand_q;
    assign start_acc   = (state_q == ST_IDLE) && start_i;
    // FIFO empty after this cycle's pop; lets DONE follow the last beat directly
    assign drain_empty = !inflight
                         && ((fifo_cnt == '0) || ((fifo_cnt == FIFO_CNT_W'(1)) && pop));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SCAN;
            ST_SCAN:  if (issue && cand_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode, registered below so status lines align with the state
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == ST_SCAN) || (state_d == ST_DRAIN)) begin
            busy_d = 1'b1;
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    // Candidate counter, label pipeline, match counter and status flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q      <= '0;
            pipe_cand_q <= '0;
            pipe_v_q    <= 1'b0;
            target_q    <= '0;
            match_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            pipe_v_q    <= issue;
            pipe_cand_q <= cand_q;
            if (start_acc) begin
                target_q    <= target_i;
                cand_q      <= '0;
                match_cnt_q <= '0;
            end else begin
                // Last candidate is never wrapped back to zero
                if (issue && !cand_last) begin
                    cand_q <= cand_q + FEAT_W'(1);
                end
                if (pop) begin
                    match_cnt_q <= match_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    dtc_sfifo #(
        .W (FEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (ret_cand),
        .rdata (m_if.m_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign m_if.m_valid_o = !fifo_empty;
    assign feat_o         = cand_q;
    assign match_cnt_o    = match_cnt_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

`ifdef DTC_PRESCAN_HIST_EN
    logic [3:0][FEAT_W:0] hist_q;

    // One count per returned label, indexed by class
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (start_acc) begin
            hist_q <= '0;
        end else if (ret_v) begin
            hist_q[cls_i[1:0]] <= hist_q[cls_i[1:0]] + CNT_W'(1);
        end
    end

    assign hist_o = hist_q;
`endif

endmodule
